// File: rtl/diff_demo_pkg.sv
// Shared types and configuration for the PE-array write-back path.
// Holds the row count and the write-back collector state encoding.
package diff_demo_pkg;

  localparam int CONF_PE_ROW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wb_coll_state_t;

endpackage

// File: rtl/wb_row_packer.sv
// One PE row: packs incoming elements into SRAM words and queues each word
// with its address in a small FIFO until the shared write port takes it.
module wb_row_packer #(
  parameter int ELEM_W     = 8,
  parameter int WORD_LANES = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12,
  parameter int ROW        = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         run_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [ADDR_W-1:0]            row_stride_i,
  input  logic [ELEM_W-1:0]            elem_i,
  input  logic                         elem_valid_i,
  input  logic                         nib_mode_i,
  input  logic                         row_finish_i,
  input  logic                         pop_i,
  output logic                         head_valid_o,
  output logic [ADDR_W-1:0]            head_addr_o,
  output logic [WORD_LANES*ELEM_W-1:0] head_wdata_o,
  output logic [WORD_LANES-1:0]        head_lmask_o,
  output logic                         finished_o,
  output logic                         idle_o,
  output logic                         overflow_o
);

  localparam int  WORD_W = WORD_LANES * ELEM_W;
  localparam int  LANE_W = $clog2(WORD_LANES + 1);
  localparam int  LIDX_W = (WORD_LANES > 1) ? $clog2(WORD_LANES) : 1;
  localparam int  PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int  CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam bit  NIB_OK = (ELEM_W == 8);

  logic [WORD_LANES-1:0][ELEM_W-1:0] word_q, n_word;
  logic [LANE_W-1:0]                 lane_q, n_lane;
  logic                              half_q, n_half;
  logic                              fin_q, n_fin, pend_q, n_pend, ovf_q;
  logic [ADDR_W-1:0]                 ptr_q;

  logic                              push, take, fin_now, nib_en;
  logic [WORD_W-1:0]                 push_data;
  logic [WORD_LANES-1:0]             push_mask;

  logic [ADDR_W-1:0]                 f_addr [FIFO_DEPTH];
  logic [WORD_W-1:0]                 f_data [FIFO_DEPTH];
  logic [WORD_LANES-1:0]             f_mask [FIFO_DEPTH];
  logic [PTR_W-1:0]                  rd_q, wr_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              full, empty, do_push, do_pop;

  // A half-filled nibble lane counts as a filled lane for the write mask.
  function automatic logic [WORD_LANES-1:0] fill_mask(input logic [LANE_W-1:0] n,
                                                      input logic              h);
    logic [WORD_LANES-1:0] m;
    int lim;
    lim = int'(n) + int'(h);
    for (int i = 0; i < WORD_LANES; i++) m[i] = (i < lim);
    return m;
  endfunction

  assign nib_en  = NIB_OK && nib_mode_i;
  assign take    = run_i && !fin_q && elem_valid_i;
  assign fin_now = run_i && !fin_q && row_finish_i;

  always_comb begin
    n_word    = word_q;
    n_lane    = lane_q;
    n_half    = half_q;
    n_fin     = fin_q;
    n_pend    = pend_q;
    push      = 1'b0;
    push_data = '0;
    push_mask = '0;
    // Flush deferred from a cycle that already pushed a completed word.
    if (pend_q) begin
      push      = 1'b1;
      push_data = word_q;
      push_mask = fill_mask(lane_q, half_q);
      n_word    = '0;
      n_lane    = '0;
      n_half    = 1'b0;
      n_pend    = 1'b0;
    end
    if (take) begin
      if (nib_en) begin
        if (half_q) begin
          n_word[LIDX_W'(lane_q)] = n_word[LIDX_W'(lane_q)] | (ELEM_W'(elem_i[3:0]) << 4);
          n_half = 1'b0;
          n_lane = lane_q + LANE_W'(1);
        end else begin
          n_word[LIDX_W'(lane_q)] = ELEM_W'(elem_i[3:0]);
          n_half = 1'b1;
        end
      end else begin
        if (half_q) begin
          n_half = 1'b0;
          n_lane = lane_q + LANE_W'(1);
          if (n_lane == LANE_W'(WORD_LANES)) begin
            push      = 1'b1;
            push_data = n_word;
            push_mask = '1;
            n_word    = '0;
            n_lane    = '0;
          end
        end
        n_word[LIDX_W'(n_lane)] = elem_i;
        n_lane = n_lane + LANE_W'(1);
      end
      if (n_lane == LANE_W'(WORD_LANES)) begin
        push      = 1'b1;
        push_data = n_word;
        push_mask = '1;
        n_word    = '0;
        n_lane    = '0;
      end
    end
    if (fin_now) begin
      n_fin = 1'b1;
      if (n_lane != '0 || n_half) begin
        if (push) begin
          n_pend = 1'b1;
        end else begin
          push      = 1'b1;
          push_data = n_word;
          push_mask = fill_mask(n_lane, n_half);
          n_word    = '0;
          n_lane    = '0;
          n_half    = 1'b0;
        end
      end
    end
  end

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      lane_q <= '0;
      half_q <= 1'b0;
      fin_q  <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      ptr_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      lane_q <= '0;
      half_q <= 1'b0;
      fin_q  <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      ptr_q  <= base_addr_i + row_stride_i * ADDR_W'(ROW);
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= n_word;
      lane_q <= n_lane;
      half_q <= n_half;
      fin_q  <= n_fin;
      pend_q <= n_pend;
      // A dropped word still consumes its address so later words stay in place.
      if (push) ptr_q <= ptr_q + ADDR_W'(1);
      if (push && full && !do_pop) ovf_q <= 1'b1;
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      if (do_push && !do_pop) cnt_q <= cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      f_addr[wr_q] <= ptr_q;
      f_data[wr_q] <= push_data;
      f_mask[wr_q] <= push_mask;
    end
  end

  assign head_valid_o = !empty;
  assign head_addr_o  = f_addr[rd_q];
  assign head_wdata_o = f_data[rd_q];
  assign head_lmask_o = f_mask[rd_q];
  assign finished_o   = fin_q;
  assign idle_o       = !pend_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/fm_wb_collector.sv
// Collects per-row write-back element streams into packed SRAM words and
// drains them round-robin through one shared write port.
module fm_wb_collector
  import diff_demo_pkg::*;
#(
  parameter int NUM_ROW    = CONF_PE_ROW,
  parameter int ELEM_W     = 8,
  parameter int WORD_LANES = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [ADDR_W-1:0]            row_stride_i,
  input  logic [NUM_ROW*ELEM_W-1:0]    elem_i,
  input  logic [NUM_ROW-1:0]           elem_valid_i,
  input  logic [NUM_ROW-1:0]           nib_mode_i,
  input  logic [NUM_ROW-1:0]           row_finish_i,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [WORD_LANES*ELEM_W-1:0] mem_wdata_o,
  output logic [WORD_LANES-1:0]        mem_lmask_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_ROW-1:0]           overflow_o,
  output wb_coll_state_t               dbg_state_o
);

  localparam int WORD_W = WORD_LANES * ELEM_W;
  localparam int SEL_W  = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

  wb_coll_state_t        state_q, state_d;
  logic                  clr, run, done;
  logic [NUM_ROW-1:0]    head_valid, row_fin, row_idle, pop;
  logic [ADDR_W-1:0]     head_addr [NUM_ROW];
  logic [WORD_W-1:0]     head_data [NUM_ROW];
  logic [WORD_LANES-1:0] head_mask [NUM_ROW];

  logic                  locked_q, found, req;
  logic [SEL_W-1:0]      sel_q, rr_q, pick, cand, sel;

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    wb_row_packer #(
      .ELEM_W    (ELEM_W),
      .WORD_LANES(WORD_LANES),
      .FIFO_DEPTH(FIFO_DEPTH),
      .ADDR_W    (ADDR_W),
      .ROW       (r)
    ) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr),
      .run_i       (run),
      .base_addr_i (base_addr_i),
      .row_stride_i(row_stride_i),
      .elem_i      (elem_i[r*ELEM_W +: ELEM_W]),
      .elem_valid_i(elem_valid_i[r]),
      .nib_mode_i  (nib_mode_i[r]),
      .row_finish_i(row_finish_i[r]),
      .pop_i       (pop[r]),
      .head_valid_o(head_valid[r]),
      .head_addr_o (head_addr[r]),
      .head_wdata_o(head_data[r]),
      .head_lmask_o(head_mask[r]),
      .finished_o  (row_fin[r]),
      .idle_o      (row_idle[r]),
      .overflow_o  (overflow_o[r])
    );
  end

  // Write handshake: a word transfers on each cycle with mem_req_o && mem_gnt_i.
  // Once mem_req_o rises, it and addr/wdata/lmask hold steady until granted.
  always_comb begin
    pick  = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_ROW; i++) begin
      cand = SEL_W'((int'(rr_q) + i) % NUM_ROW);
      if (!found && head_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel = locked_q ? sel_q : pick;
  assign req = locked_q || (|head_valid);

  always_comb begin
    pop = '0;
    if (req && mem_gnt_i) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      sel_q    <= '0;
      rr_q     <= '0;
    end else if (req) begin
      if (mem_gnt_i) begin
        locked_q <= 1'b0;
        rr_q     <= (sel == SEL_W'(NUM_ROW - 1)) ? '0 : sel + SEL_W'(1);
      end else begin
        locked_q <= 1'b1;
        sel_q    <= sel;
      end
    end
  end

  assign mem_req_o   = req;
  assign mem_addr_o  = req ? head_addr[sel] : '0;
  assign mem_wdata_o = req ? head_data[sel] : '0;
  assign mem_lmask_o = req ? head_mask[sel] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (&row_fin) state_d = DRAIN;
      end
      DRAIN: begin
        if (!(|head_valid) && (&row_idle) && !req) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run         = (state_q == RUN);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fm_wb_collector.sv
// Self-checking bench for fm_wb_collector: directed packing table, multi-cycle
// corner sequences, and randomized layers against a queue-based packing model.
module tb_fm_wb_collector;
  import diff_demo_pkg::*;

  localparam int NR = 4;
  localparam int EW = 8;
  localparam int WL = 8;
  localparam int FD = 4;
  localparam int AW = 12;
  localparam int WW = WL * EW;
  localparam int RW = AW + WW + WL;

  logic           clk, rst_n, start_i;
  logic [AW-1:0]  base_addr_i, row_stride_i;
  logic [NR*EW-1:0] elem_i;
  logic [NR-1:0]  elem_valid_i, nib_mode_i, row_finish_i;
  logic           mem_req_o, mem_gnt_i;
  logic [AW-1:0]  mem_addr_o;
  logic [WW-1:0]  mem_wdata_o;
  logic [WL-1:0]  mem_lmask_o;
  logic           busy_o, done_o;
  logic [NR-1:0]  overflow_o;
  wb_coll_state_t dbg_state_o;

  fm_wb_collector #(
    .NUM_ROW(NR), .ELEM_W(EW), .WORD_LANES(WL), .FIFO_DEPTH(FD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .base_addr_i(base_addr_i), .row_stride_i(row_stride_i),
    .elem_i(elem_i), .elem_valid_i(elem_valid_i), .nib_mode_i(nib_mode_i),
    .row_finish_i(row_finish_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_lmask_o(mem_lmask_o),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
    .dbg_state_o(dbg_state_o)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int gnt_mode = 1;
  int gnt_ph = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  logic [RW-1:0] hold, cur;
  bit            hold_v = 0;
  logic [AW-1:0] cur_base, cur_stride;

  logic [7:0]    m_lanes [NR][$];
  bit            m_open  [NR];
  logic [AW-1:0] m_ptr   [NR];

  typedef struct {
    int          n;
    logic [15:0] nib;
    logic [63:0] data;
    logic [7:0]  mask;
  } vec_t;
  vec_t vt[6];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // grant driver
  initial begin
    mem_gnt_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0: mem_gnt_i = 1'b0;
        1: mem_gnt_i = 1'b1;
        2: begin
          gnt_ph = (gnt_ph + 1) % 3;
          mem_gnt_i = (gnt_ph == 0);
        end
        default: mem_gnt_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // monitor: records granted writes, checks payload stability while waiting
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (done_o) done_cnt++;
      if (mem_req_o) begin
        cur = {mem_addr_o, mem_wdata_o, mem_lmask_o};
        if (hold_v) check("req_stable", cur, hold);
        if (mem_gnt_i) begin
          obs_q.push_back(cur);
          hold_v = 0;
        end else begin
          hold   = cur;
          hold_v = 1;
        end
      end else begin
        if (hold_v) check("req_held", mem_req_o, 1);
        hold_v = 0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i      = 1'b0;
    elem_i       = '0;
    elem_valid_i = '0;
    nib_mode_i   = '0;
    row_finish_i = '0;
  endtask

  task automatic m_init(input logic [AW-1:0] b, input logic [AW-1:0] s);
    for (int r = 0; r < NR; r++) begin
      m_lanes[r].delete();
      m_open[r] = 0;
      m_ptr[r]  = AW'(b + s * AW'(r));
    end
  endtask

  task automatic start_layer(input logic [AW-1:0] b, input logic [AW-1:0] s);
    base_addr_i  = b;
    row_stride_i = s;
    cur_base     = b;
    cur_stride   = s;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    m_init(b, s);
  endtask

  task automatic send_row0(input logic [7:0] e, input bit nib, input bit fin);
    elem_i       = '0;
    elem_i[7:0]  = e;
    elem_valid_i = 4'b0001;
    nib_mode_i   = {3'b000, nib};
    row_finish_i = fin ? '1 : '0;
    step();
    idle_inputs();
  endtask

  task automatic finish_all();
    row_finish_i = '1;
    step();
    idle_inputs();
  endtask

  task automatic wait_done(input string name);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 2000) begin
      step();
      n++;
    end
    check(name, (done_cnt != d0), 1);
    check({name, "_idle"}, busy_o, 0);
  endtask

  // reference model: lanes as a byte queue per row, one open nibble flag
  task automatic m_emit(input int r);
    logic [WW-1:0] d;
    logic [WL-1:0] m;
    d = '0;
    m = '0;
    for (int i = 0; i < m_lanes[r].size(); i++) begin
      d[i*8 +: 8] = m_lanes[r][i];
      m[i] = 1'b1;
    end
    exp_q.push_back({m_ptr[r], d, m});
    m_ptr[r] = m_ptr[r] + 1'b1;
    m_lanes[r].delete();
    m_open[r] = 0;
  endtask

  task automatic m_elem(input int r, input logic [7:0] e, input bit nib);
    if (nib) begin
      if (m_open[r]) begin
        m_lanes[r][m_lanes[r].size()-1] = m_lanes[r][m_lanes[r].size()-1] | {e[3:0], 4'h0};
        m_open[r] = 0;
        if (m_lanes[r].size() == WL) m_emit(r);
      end else begin
        m_lanes[r].push_back({4'h0, e[3:0]});
        m_open[r] = 1;
      end
    end else begin
      m_open[r] = 0;
      if (m_lanes[r].size() == WL) m_emit(r);
      m_lanes[r].push_back(e);
      if (m_lanes[r].size() == WL) m_emit(r);
    end
  endtask

  task automatic m_finish(input int r);
    if (m_lanes[r].size() > 0) m_emit(r);
  endtask

  function automatic int row_of(input logic [RW-1:0] rec);
    logic [AW-1:0] a;
    a = rec[RW-1 -: AW] - cur_base;
    return int'(a / cur_stride);
  endfunction

  // scoreboard comparison of observed writes against the expected queue
  task automatic compare_writes(input string name, input bit ordered);
    logic [RW-1:0] eq[$];
    logic [RW-1:0] oq[$];
    check({name, "_count"}, obs_q.size(), exp_q.size());
    if (ordered) begin
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        check(name, obs_q[i], exp_q[i]);
    end else begin
      for (int r = 0; r < NR; r++) begin
        eq.delete();
        oq.delete();
        foreach (exp_q[i]) if (row_of(exp_q[i]) == r) eq.push_back(exp_q[i]);
        foreach (obs_q[i]) if (row_of(obs_q[i]) == r) oq.push_back(obs_q[i]);
        check($sformatf("%s_row%0d_count", name, r), oq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < oq.size(); i++)
          check($sformatf("%s_row%0d", name, r), oq[i], eq[i]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    vt[0] = '{8,  16'h0000, 64'h0807060504030201, 8'hFF};
    vt[1] = '{5,  16'h001F, 64'h0000000000054321, 8'h07};
    vt[2] = '{3,  16'h0000, 64'h0000000000030201, 8'h07};
    vt[3] = '{4,  16'h0007, 64'h0000000000040321, 8'h07};
    vt[4] = '{1,  16'h0001, 64'h0000000000000001, 8'h01};
    vt[5] = '{16, 16'hFFFF, 64'h0FEDCBA987654321, 8'hFF};

    idle_inputs();
    base_addr_i  = '0;
    row_stride_i = '0;
    cur_base     = '0;
    cur_stride   = 12'h001;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_state", dbg_state_o, IDLE);
    rst_n = 1'b1;
    step();
    check("rst_addr", mem_addr_o, 0);

    // four rows, one element each with finish in the same cycle, sparse grant
    gnt_mode = 2;
    start_layer(12'h100, 12'h020);
    check("seqa_state", dbg_state_o, RUN);
    elem_i       = 32'h13121110;
    elem_valid_i = '1;
    row_finish_i = '1;
    step();
    idle_inputs();
    wait_done("seqa_done");
    for (int r = 0; r < NR; r++)
      exp_q.push_back({AW'(12'h100 + 12'h020 * r), WW'(8'h10 + r), 8'h01});
    compare_writes("seqa_rr", 1);

    // table-driven single-row packing cases
    gnt_mode = 1;
    for (int i = 0; i < 6; i++) begin
      start_layer(12'h040, 12'h010);
      check($sformatf("vec%0d_busy", i), busy_o, 1);
      for (int k = 0; k < vt[i].n; k++) send_row0(8'(k + 1), vt[i].nib[k], 1'b0);
      finish_all();
      wait_done($sformatf("vec%0d_done", i));
      exp_q.push_back({12'h040, vt[i].data, vt[i].mask});
      compare_writes($sformatf("vec%0d", i), 1);
    end

    // byte after half nibble in the last lane, finish in that same cycle
    start_layer(12'h080, 12'h010);
    for (int k = 1; k <= 7; k++) send_row0(8'(k), 1'b0, 1'b0);
    send_row0(8'h08, 1'b1, 1'b0);
    send_row0(8'h09, 1'b0, 1'b1);
    wait_done("seqe_done");
    exp_q.push_back({12'h080, 64'h0807060504030201, 8'hFF});
    exp_q.push_back({12'h081, 64'h0000000000000009, 8'h01});
    compare_writes("seqe_split", 1);

    // overflow: grant held low while row 0 produces five full words
    gnt_mode = 0;
    start_layer(12'h200, 12'h010);
    for (int k = 0; k < 40; k++) send_row0(8'(k), 1'b0, 1'b0);
    finish_all();
    step();
    check("ovf_flag", overflow_o, 4'b0001);
    check("ovf_no_write", obs_q.size(), 0);
    gnt_mode = 1;
    wait_done("ovf_done");
    for (int w = 0; w < 4; w++) begin
      logic [WW-1:0] d;
      for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'(w * 8 + b);
      exp_q.push_back({AW'(12'h200 + w), d, 8'hFF});
    end
    compare_writes("ovf_words", 1);
    check("ovf_sticky", overflow_o, 4'b0001);

    // address wrap
    start_layer(12'hFFF, 12'h001);
    check("wrap_ovf_clr", overflow_o, 0);
    for (int k = 0; k < 16; k++) send_row0(8'(8'hA0 + k), 1'b0, 1'b0);
    finish_all();
    wait_done("wrap_done");
    exp_q.push_back({12'hFFF, 64'hA7A6A5A4A3A2A1A0, 8'hFF});
    exp_q.push_back({12'h000, 64'hAFAEADACABAAA9A8, 8'hFF});
    compare_writes("wrap", 1);

    // request latency, then reset while a request is pending
    gnt_mode = 0;
    start_layer(12'h300, 12'h010);
    for (int k = 1; k <= 7; k++) send_row0(8'(k), 1'b0, 1'b0);
    check("req_early", mem_req_o, 0);
    send_row0(8'h08, 1'b0, 1'b0);
    check("req_latency", mem_req_o, 1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_state", dbg_state_o, IDLE);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid_nowrite", obs_q.size(), 0);
    gnt_mode = 1;
    start_layer(12'h300, 12'h010);
    send_row0(8'h5A, 1'b0, 1'b1);
    wait_done("restart_done");
    exp_q.push_back({12'h300, 64'h000000000000005A, 8'h01});
    compare_writes("restart", 1);

    // randomized layers against the reference model
    gnt_mode = 3;
    for (int layer = 0; layer < 3; layer++) begin
      start_layer(12'h100, 12'h100);
      for (int cyc = 0; cyc <= 120; cyc++) begin
        for (int r = 0; r < NR; r++) begin
          logic v;
          logic nb;
          logic [7:0] e;
          v  = ($urandom_range(0, 2) == 0);
          nb = 1'($urandom_range(0, 1));
          e  = 8'($urandom_range(0, 255));
          elem_valid_i[r]        = v;
          nib_mode_i[r]          = nb;
          elem_i[r*EW +: EW]     = e;
          if (v) m_elem(r, e, nb);
        end
        row_finish_i = (cyc == 120) ? '1 : '0;
        step();
      end
      idle_inputs();
      for (int r = 0; r < NR; r++) m_finish(r);
      wait_done($sformatf("rand%0d_done", layer));
      check($sformatf("rand%0d_ovf", layer), overflow_o, 0);
      compare_writes($sformatf("rand%0d", layer), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
